regfile_mp: RTL

//  Parametrised multi-port integer register file; successor of the single-write/dual-read file.

---
 rtl/regfile_mp.sv | 90 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero r0 and a post-reset scrub that clears every entry.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_N = 32,
  parameter int SIZE   = 32,
  parameter int NUM_RP = 2,
  parameter int NUM_WP = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_WP-1:0]                 wr_en,
  input  logic [NUM_WP*$clog2(SIZE)-1:0]    wr_addr,
  input  logic [NUM_WP*DATA_N-1:0]          wr_data,
  input  logic [NUM_RP*$clog2(SIZE)-1:0]    rs_addr,
  output logic [NUM_RP*DATA_N-1:0]          rs_data,
  input  logic [$clog2(SIZE)-1:0]           dbg_addr,
  output logic [DATA_N-1:0]                 dbg_data,
  output logic                              init_done
);
  localparam int ADDR_W = $clog2(SIZE);

  typedef enum logic {SCRUB, READY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] scrub_cnt_reg, scrub_cnt_next;
  logic              init_done_reg;
  logic [DATA_N-1:0] regs [SIZE];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= SCRUB;
      scrub_cnt_reg <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      scrub_cnt_reg <= scrub_cnt_next;
      init_done_reg <= (state_next == READY);
    end
  end

  always_comb begin
    state_next     = state_reg;
    scrub_cnt_next = scrub_cnt_reg;
    case (state_reg)
      SCRUB: begin
        scrub_cnt_next = scrub_cnt_reg + 1'b1;
        if (scrub_cnt_reg == ADDR_W'(SIZE - 1)) state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = SCRUB;
    endcase
  end

  // Ascending port order makes the highest-numbered port win an address collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_reg == SCRUB) begin
        regs[scrub_cnt_reg] <= '0;
      end else begin
        for (int p = 0; p < NUM_WP; p++) begin
          if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0))
            regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_N +: DATA_N];
        end
      end
    end
  end

  function automatic logic [DATA_N-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_N-1:0] val;
    val = regs[addr];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NUM_WP; p++) begin
      if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == addr))
        val = wr_data[p*DATA_N +: DATA_N];
    end
`endif
    // Unscrubbed contents and r0 must never leak out, forwarded or not.
    if (!init_done_reg || (addr == '0)) val = '0;
    return val;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_RP; gi++) begin : g_rd
      assign rs_data[gi*DATA_N +: DATA_N] = read_port(rs_addr[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  assign dbg_data  = read_port(dbg_addr);
  assign init_done = init_done_reg;
endmodule
